iir_out_checker: RTL and testbench
==================================

# iir_out_checker

Synthesizable result checker at the output end of the IIR datapath. It consumes the filter's sample stream (DOUT/VOUT), compares each valid sample against a preloaded table of expected values within a signed tolerance, and counts mismatches. It records the first failing index and reports pass/fail. It replaces the behavioural data sink for on-chip and FPGA self-test, sitting between `myiir` and the status/readout logic.

## Interface
Parameters:
- `W`, 9: sample width, two's complement.
- `DEPTH`, 64: expected-table entries, power of two.
- `AW`, 6: table address width, equal to log2(`DEPTH`).
- `TOL`, 0: maximum allowed absolute difference, in LSBs.
- `TMO`, 255: idle cycles in RUN before a timeout is declared.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `EXP_WE` in 1: write strobe for the expected table.
- `EXP_ADDR` in `AW`: expected-table write address.
- `EXP_DATA` in `W`: expected value to write.
- `START` in 1: one-cycle pulse that arms a check run.
- `NUM` in `AW`+1: number of samples to check, 1..`DEPTH`.
- `VIN` in 1: sample valid, driven from the filter's VOUT.
- `DIN` in `W`: sample, driven from the filter's DOUT.
- `BUSY` out 1: high while in RUN.
- `DONE` out 1: high in DONE; held until the next START.
- `PASS` out 1: valid when `DONE`=1; set when `ERR_CNT`=0 and no timeout.
- `TIMEOUT` out 1: run ended on the idle timeout.
- `ERR_CNT` out `AW`+1: mismatch count, saturating.
- `FIRST_ERR` out `AW`: index of the first mismatch.
- `FIRST_VLD` out 1: `FIRST_ERR` holds a valid index.
- `SAMP_CNT` out `AW`+1: samples accepted in the current or last run.

## Operation
- Expected table is a `DEPTH`×`W` register array.
  - Write is synchronous on `EXP_WE`, accepted in any state.
  - Read is combinational, addressed by `SAMP_CNT[AW-1:0]`.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `START`. Entry clears `SAMP_CNT`, `ERR_CNT`, `FIRST_VLD`, `TIMEOUT` and the idle counter, and latches `NUM`.
  - RUN: each cycle with `VIN`=1 is one accepted sample.
    - Compute diff = sign-extended `DIN` minus expected, in `W`+1 bits.
    - Mismatch when |diff| > `TOL`.
    - A mismatch increments `ERR_CNT`, saturating at 2^(`AW`+1)−1.
    - On the first mismatch only, `FIRST_ERR` ← current index and `FIRST_VLD` ← 1.
    - Every accepted sample increments `SAMP_CNT`.
  - RUN→DONE when the accepted sample makes `SAMP_CNT` equal the latched NUM.
  - RUN→DONE with `TIMEOUT`=1 when the idle counter reaches `TMO`. The idle counter increments on each `VIN`=0 cycle and clears on `VIN`=1.
  - DONE→RUN on `START`, with the same clears as from IDLE.
- `VIN` is ignored in IDLE and DONE; samples there are neither counted nor compared.
- `START` during RUN is ignored.
- Latched NUM of 0 or greater than `DEPTH` is clamped to `DEPTH`.
- `EXP_WE` during RUN to the address currently being read: the comparison uses the old value, and the write takes effect at the edge.

## Timing
- On `RST`, all outputs and state go to 0 and the FSM goes to IDLE. This applies mid-run too: partial results are discarded. The expected table is not reset.
- Comparison latency is one cycle: a sample at edge k is reflected in `ERR_CNT`/`SAMP_CNT` after edge k.
- `BUSY` rises the cycle after `START`.
- `DONE` and `PASS` assert in the cycle after the final accepted sample. `BUSY` falls in the same cycle.
- Back-to-back `VIN` is supported at one sample per clock, with no stall.
- Timeout: with no `VIN` for `TMO` consecutive RUN cycles, `DONE`=1 and `TIMEOUT`=1 on the next edge.

## Structure
- Shared package `iir_pkg` holds:
  - the sample width constant (9);
  - the FSM state encoding (IDLE=0, RUN=1, DONE=2);
  - a signed-difference helper function (width `W`+1).
- One sub-module, `exp_table`: the register-array expected memory (write port plus asynchronous read port).
- FSM, counters and comparator live in the top module.

## Test plan
- Exact match: load 8 expected values {0, 5, −3, 255, −256, 1, 2, 7}, START with `NUM`=8, drive the same values on consecutive cycles → `DONE`=1, `PASS`=1, `ERR_CNT`=0, `SAMP_CNT`=8, `FIRST_VLD`=0.
- Mismatches: as above but index 2 driven as −1 and index 5 driven as 9, `TOL`=0 → `ERR_CNT`=2, `FIRST_ERR`=2, `PASS`=0.
- Tolerance: build with `TOL`=1; expected 100, driven 101 and then 98 → the first passes and the second counts, giving `ERR_CNT`=1. Signed wrap case: expected −256, driven 255 → counted as a mismatch (diff=511).
- Gapped and timeout: `NUM`=4, `VIN` pulsed every 3rd cycle → completes with `PASS`=1. Then `NUM`=4 with only 2 samples followed by silence → `TIMEOUT`=1, `PASS`=0, `SAMP_CNT`=2, exactly `TMO` cycles after the last `VIN`.
- Reset and restart: assert `RST` after 3 of 8 samples → all outputs 0 and state IDLE. Then START with `NUM`=0 → runs to `DEPTH` samples. A START issued during RUN has no effect.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR output checker: sample width, FSM state
// encoding and the widened signed-difference helper.
package iir_pkg;

    localparam int SAMPLE_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sign-extend both operands by one bit before subtracting so that the
    // full range (-256 - 255 .. 255 - -256) is representable without wrap.
    function automatic logic signed [SAMPLE_W:0] sdiff(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        logic signed [SAMPLE_W:0] a_ext;
        logic signed [SAMPLE_W:0] b_ext;
        a_ext = {a[SAMPLE_W-1], a};
        b_ext = {b[SAMPLE_W-1], b};
        return a_ext - b_ext;
    endfunction

endpackage

// File: rtl/iir_out_checker_if.sv
// Bundle of the checker's table-load, run-control, sample-stream and status
// signals. The master side (test logic / readout) drives the controls and
// samples; the slave side (the checker) drives the status.
interface iir_out_checker_if
    import iir_pkg::*;
#(
    parameter int W  = SAMPLE_W,
    parameter int AW = 6
);
    logic          EXP_WE;
    logic [AW-1:0] EXP_ADDR;
    logic [W-1:0]  EXP_DATA;
    logic          START;
    logic [AW:0]   NUM;
    logic          VIN;
    logic [W-1:0]  DIN;
    logic          BUSY;
    logic          DONE;
    logic          PASS;
    logic          TIMEOUT;
    logic [AW:0]   ERR_CNT;
    logic [AW-1:0] FIRST_ERR;
    logic          FIRST_VLD;
    logic [AW:0]   SAMP_CNT;

    modport master (
        output EXP_WE, EXP_ADDR, EXP_DATA, START, NUM, VIN, DIN,
        input  BUSY, DONE, PASS, TIMEOUT, ERR_CNT, FIRST_ERR, FIRST_VLD, SAMP_CNT
    );

    modport slave (
        input  EXP_WE, EXP_ADDR, EXP_DATA, START, NUM, VIN, DIN,
        output BUSY, DONE, PASS, TIMEOUT, ERR_CNT, FIRST_ERR, FIRST_VLD, SAMP_CNT
    );
endinterface

// File: rtl/exp_table.sv
// Expected-value memory: register array with a synchronous write port and a
// combinational read port. Contents survive reset on purpose so a table can
// be loaded once and reused across runs.
module exp_table
    import iir_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    // Write lands at the clock edge; a same-cycle read still sees the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/iir_out_checker.sv
// Result checker for the IIR output stream: compares each valid sample with
// the expected table within +/-TOL, counts mismatches, remembers the first
// failing index and reports pass/fail or an idle timeout.
module iir_out_checker
    import iir_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int TOL   = 0,
    parameter int TMO   = 255
) (
    input  logic             CLK,
    input  logic             RST,
    iir_out_checker_if.slave bus
);
    // Idle counter only has to reach TMO-1; the expiring cycle moves to DONE.
    localparam int          IW      = (TMO < 2) ? 1 : $clog2(TMO);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TMO - 1);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_timeout;
    logic            r_first_vld;
    logic [AW-1:0]   r_first_err;
    logic [AW:0]     r_samp_cnt;
    logic [AW:0]     r_err_cnt;
    logic [AW:0]     r_num;
    logic [IW-1:0]   r_idle;

    logic [W-1:0]    w_exp;
    logic signed [W:0] w_diff;
    logic [W:0]      w_abs;
    logic            w_mismatch;
    logic [AW:0]     w_samp_inc;
    logic [AW:0]     w_err_inc;
    logic [AW:0]     w_num_clamp;
    logic            w_last;

    exp_table #(
        .W    (W),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_exp_table (
        .i_clk  (CLK),
        .i_we   (bus.EXP_WE),
        .i_waddr(bus.EXP_ADDR),
        .i_wdata(bus.EXP_DATA),
        .i_raddr(r_samp_cnt[AW-1:0]),
        .o_rdata(w_exp)
    );

    // Comparator, saturating increment and NUM clamp for the current cycle.
    always_comb begin
        w_diff      = sdiff(bus.DIN, w_exp);
        w_abs       = w_diff[W] ? -w_diff : w_diff;
        w_mismatch  = int'(w_abs) > TOL;
        w_samp_inc  = r_samp_cnt + (AW+1)'(1);
        w_err_inc   = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + (AW+1)'(1);
        w_last      = (w_samp_inc == r_num);
        w_num_clamp = ((bus.NUM == '0) || (bus.NUM > DEPTH_V)) ? DEPTH_V : bus.NUM;
    end

    // Run-control FSM with all status outputs registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_first_vld <= 1'b0;
            r_first_err <= '0;
            r_samp_cnt  <= '0;
            r_err_cnt   <= '0;
            r_num       <= '0;
            r_idle      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_first_vld <= 1'b0;
                        r_samp_cnt  <= '0;
                        r_err_cnt   <= '0;
                        r_idle      <= '0;
                        r_num       <= w_num_clamp;
                    end
                end
                ST_RUN: begin
                    if (bus.VIN) begin
                        r_idle     <= '0;
                        r_samp_cnt <= w_samp_inc;
                        if (w_mismatch) begin
                            r_err_cnt <= w_err_inc;
                            if (!r_first_vld) begin
                                r_first_err <= r_samp_cnt[AW-1:0];
                                r_first_vld <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= !w_mismatch && (r_err_cnt == '0);
                        end
                    end else begin
                        r_idle <= r_idle + IW'(1);
                        if (r_idle == IDLE_LAST) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_pass    <= 1'b0;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.PASS      = r_pass;
    assign bus.TIMEOUT   = r_timeout;
    assign bus.ERR_CNT   = r_err_cnt;
    assign bus.FIRST_ERR = r_first_err;
    assign bus.FIRST_VLD = r_first_vld;
    assign bus.SAMP_CNT  = r_samp_cnt;
endmodule

// File: tb/tb_iir_out_checker.sv
// Bench for iir_out_checker: two instances (TOL=0 and TOL=1) see identical
// stimulus; expected run results are queued per instance at stimulus time
// and a monitor pops and compares them whenever DONE rises.
module tb_iir_out_checker;
    import iir_pkg::*;

    localparam int W     = SAMPLE_W;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int TMO   = 255;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          exp_we   = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [W-1:0]  exp_data = '0;
    logic          start    = 1'b0;
    logic [AW:0]   num      = '0;
    logic          vin      = 1'b0;
    logic [W-1:0]  din      = '0;

    iir_out_checker_if #(.W(W), .AW(AW)) if0 ();
    iir_out_checker_if #(.W(W), .AW(AW)) if1 ();

    assign if0.EXP_WE = exp_we;   assign if1.EXP_WE = exp_we;
    assign if0.EXP_ADDR = exp_addr; assign if1.EXP_ADDR = exp_addr;
    assign if0.EXP_DATA = exp_data; assign if1.EXP_DATA = exp_data;
    assign if0.START = start;     assign if1.START = start;
    assign if0.NUM = num;         assign if1.NUM = num;
    assign if0.VIN = vin;         assign if1.VIN = vin;
    assign if0.DIN = din;         assign if1.DIN = din;

    iir_out_checker #(.W(W), .DEPTH(DEPTH), .AW(AW), .TOL(0), .TMO(TMO)) dut0 (
        .CLK(clk), .RST(rst), .bus(if0)
    );
    iir_out_checker #(.W(W), .DEPTH(DEPTH), .AW(AW), .TOL(1), .TMO(TMO)) dut1 (
        .CLK(clk), .RST(rst), .bus(if1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pass;
        bit tmo;
        int err;
        int ferr;
        bit fvld;
        int samp;
        int lat;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_val(input int i);
        case (i)
            0:  return 0;
            1:  return 5;
            2:  return -3;
            3:  return 255;
            4:  return -256;
            5:  return 1;
            6:  return 2;
            7:  return 7;
            8:  return 100;
            9:  return 100;
            10: return -256;
            default: return i - 32;
        endcase
    endfunction

    function automatic res_t get_act(input int d);
        res_t r;
        if (d == 0) begin
            r.pass = if0.PASS;  r.tmo = if0.TIMEOUT; r.err = int'(if0.ERR_CNT);
            r.ferr = int'(if0.FIRST_ERR); r.fvld = if0.FIRST_VLD; r.samp = int'(if0.SAMP_CNT);
        end else begin
            r.pass = if1.PASS;  r.tmo = if1.TIMEOUT; r.err = int'(if1.ERR_CNT);
            r.ferr = int'(if1.FIRST_ERR); r.fvld = if1.FIRST_VLD; r.samp = int'(if1.SAMP_CNT);
        end
        r.lat = 0;
        return r;
    endfunction

    function automatic bit get_busy(input int d);
        return (d == 0) ? if0.BUSY : if1.BUSY;
    endfunction

    function automatic bit get_done(input int d);
        return (d == 0) ? if0.DONE : if1.DONE;
    endfunction

    task automatic expect_run(input int d, input bit p, input bit t, input int e,
                              input int fe, input bit fv, input int s, input int l);
        res_t r;
        r.pass = p; r.tmo = t; r.err = e; r.ferr = fe; r.fvld = fv; r.samp = s; r.lat = l;
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic compare(input string tag, input res_t e, input res_t a);
        chk({tag, " pass"},      a.pass, e.pass);
        chk({tag, " timeout"},   a.tmo,  e.tmo);
        chk({tag, " err_cnt"},   a.err,  e.err);
        chk({tag, " first_vld"}, a.fvld, e.fvld);
        if (e.fvld) chk({tag, " first_err"}, a.ferr, e.ferr);
        chk({tag, " samp_cnt"},  a.samp, e.samp);
        chk({tag, " done latency"}, a.lat, e.lat);
    endtask

    task automatic check_zero(input string tag);
        res_t a;
        for (int d = 0; d < 2; d++) begin
            a = get_act(d);
            chk($sformatf("%s dut%0d busy", tag, d),      get_busy(d), 0);
            chk($sformatf("%s dut%0d done", tag, d),      get_done(d), 0);
            chk($sformatf("%s dut%0d pass", tag, d),      a.pass, 0);
            chk($sformatf("%s dut%0d timeout", tag, d),   a.tmo,  0);
            chk($sformatf("%s dut%0d err_cnt", tag, d),   a.err,  0);
            chk($sformatf("%s dut%0d first_err", tag, d), a.ferr, 0);
            chk($sformatf("%s dut%0d first_vld", tag, d), a.fvld, 0);
            chk($sformatf("%s dut%0d samp_cnt", tag, d),  a.samp, 0);
        end
    endtask

    task automatic drive(input logic v, input int d);
        @(negedge clk);
        vin = v;
        din = W'(d);
    endtask

    task automatic load(input int addr, input int val);
        @(negedge clk);
        exp_we   = 1'b1;
        exp_addr = AW'(addr);
        exp_data = W'(val);
    endtask

    task automatic start_run(input int n, input string tag);
        @(negedge clk);
        start = 1'b1;
        num   = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy after start"}, if0.BUSY, 1);
        chk({tag, " done cleared"},     if0.DONE, 0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        @(negedge clk);
        vin = 1'b0;
        n = 0;
        while (!(if0.DONE && if1.DONE) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done within budget"}, int'(if0.DONE && if1.DONE), 1);
        chk({tag, " busy low at done"}, if0.BUSY, 0);
    endtask

    // Scoreboard monitor: tracks the last accepted sample edge and checks each
    // completed run against the queued expectation.
    initial begin : monitor
        int   edge_n;
        int   last_v [2];
        bit   prev_busy [2];
        bit   prev_done [2];
        res_t a;
        res_t e;
        edge_n = 0;
        for (int d = 0; d < 2; d++) begin
            last_v[d] = 0; prev_busy[d] = 1'b0; prev_done[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            for (int d = 0; d < 2; d++) begin
                if (prev_busy[d] && vin) last_v[d] = edge_n;
                if (get_done(d) && !prev_done[d]) begin
                    a = get_act(d);
                    a.lat = edge_n - last_v[d];
                    if (d == 0) begin
                        chk("dut0 result expected", int'(q0.size() != 0), 1);
                        if (q0.size() != 0) begin
                            e = q0.pop_front();
                            compare("dut0", e, a);
                        end
                    end else begin
                        chk("dut1 result expected", int'(q1.size() != 0), 1);
                        if (q1.size() != 0) begin
                            e = q1.pop_front();
                            compare("dut1", e, a);
                        end
                    end
                end
                prev_busy[d] = get_busy(d);
                prev_done[d] = get_done(d);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time %0t reached, required finish before it", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Samples outside RUN must be ignored.
        drive(1'b1, 5);
        drive(1'b1, 7);
        drive(1'b0, 0);
        @(negedge clk);
        chk("idle vin samp_cnt", if0.SAMP_CNT, 0);
        chk("idle vin busy", if0.BUSY, 0);

        for (int i = 0; i < DEPTH; i++) load(i, exp_val(i));
        @(negedge clk);
        exp_we = 1'b0;

        // Exact match over the first 8 entries.
        expect_run(0, 1, 0, 0, 0, 0, 8, 0);
        expect_run(1, 1, 0, 0, 0, 0, 8, 0);
        start_run(8, "exact");
        for (int i = 0; i < 8; i++) drive(1'b1, exp_val(i));
        wait_done(20, "exact");
        repeat (3) @(negedge clk);
        chk("exact done held", if0.DONE, 1);

        // Two mismatches at indices 2 and 5 (diffs +2 and +8).
        expect_run(0, 0, 0, 2, 2, 1, 8, 0);
        expect_run(1, 0, 0, 2, 2, 1, 8, 0);
        start_run(8, "mismatch");
        for (int i = 0; i < 8; i++) begin
            v = (i == 2) ? -1 : (i == 5) ? 9 : exp_val(i);
            drive(1'b1, v);
        end
        wait_done(20, "mismatch");

        // Tolerance: 101 vs 100 (diff 1), 98 vs 100 (diff 2), 255 vs -256 (511).
        expect_run(0, 0, 0, 3, 8, 1, 11, 0);
        expect_run(1, 0, 0, 2, 9, 1, 11, 0);
        start_run(11, "tolerance");
        for (int i = 0; i < 8; i++) drive(1'b1, exp_val(i));
        drive(1'b1, 101);
        drive(1'b1, 98);
        drive(1'b1, 255);
        wait_done(20, "tolerance");

        // Gapped stream: one sample every third cycle.
        expect_run(0, 1, 0, 0, 0, 0, 4, 0);
        expect_run(1, 1, 0, 0, 0, 0, 4, 0);
        start_run(4, "gapped");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, exp_val(i));
            if (i < 3) begin
                drive(1'b0, 0);
                drive(1'b0, 0);
            end
        end
        wait_done(20, "gapped");

        // Timeout: 2 of 4 samples then silence.
        expect_run(0, 0, 1, 0, 0, 0, 2, TMO);
        expect_run(1, 0, 1, 0, 0, 0, 2, TMO);
        start_run(4, "timeout");
        drive(1'b1, exp_val(0));
        drive(1'b1, exp_val(1));
        wait_done(TMO + 20, "timeout");
        chk("timeout flag", if0.TIMEOUT, 1);

        // Reset mid-run discards partial results.
        start_run(8, "abort");
        drive(1'b1, exp_val(0));
        drive(1'b1, exp_val(1) + 4);
        drive(1'b1, exp_val(2));
        @(negedge clk);
        chk("abort mid samp_cnt", if0.SAMP_CNT, 3);
        chk("abort mid err_cnt", if0.ERR_CNT, 1);
        chk("abort mid first_err", if0.FIRST_ERR, 1);
        vin = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("mid-run reset");
        @(negedge clk);
        rst = 1'b0;

        // NUM=0 runs the full table; a START mid-run is ignored. Index 40 is
        // off by one: a miss for TOL=0, a hit for TOL=1.
        expect_run(0, 0, 0, 1, 40, 1, 64, 0);
        expect_run(1, 1, 0, 0, 0, 0, 64, 0);
        start_run(0, "full");
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 40) ? exp_val(i) + 1 : exp_val(i);
            drive(1'b1, v);
            start = (i == 10);
            num   = (i == 10) ? (AW+1)'(5) : '0;
        end
        start = 1'b0;
        wait_done(20, "full");

        repeat (3) @(negedge clk);
        chk("dut0 expectations drained", q0.size(), 0);
        chk("dut1 expectations drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
